// File: rtl/instr_enc.sv
// instr_enc: turns symbolic (op_id + fields) instructions into canonical MIPS
// words and streams them into IMEM through a one-entry output register.
module instr_enc #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic [AW-1:0] base_addr_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic          in_last_i,
   input  logic [5:0]    op_id_i,
   input  logic [4:0]    rs_i,
   input  logic [4:0]    rt_i,
   input  logic [4:0]    rd_i,
   input  logic [4:0]    shamt_i,
   input  logic [15:0]   imm_i,
   input  logic [25:0]   target_i,
   output logic          imem_we_o,
   input  logic          imem_ready_i,
   output logic [AW-1:0] imem_addr_o,
   output logic [31:0]   imem_wdata_o,
   output logic          busy_o,
   output logic          done_o,
   output logic [AW:0]   word_cnt_o,
   output logic          err_bad_op_o,
   output logic          overflow_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // op_id numbering follows the decoder's one-hot instr_index bit order.
   localparam logic [5:0] OP_ADD   = 6'd0,  OP_ADDU  = 6'd1,  OP_SUB   = 6'd2,  OP_SUBU  = 6'd3;
   localparam logic [5:0] OP_AND   = 6'd4,  OP_OR    = 6'd5,  OP_XOR   = 6'd6,  OP_NOR   = 6'd7;
   localparam logic [5:0] OP_SLT   = 6'd8,  OP_SLTU  = 6'd9,  OP_SLL   = 6'd10, OP_SRL   = 6'd11;
   localparam logic [5:0] OP_SRA   = 6'd12, OP_SLLV  = 6'd13, OP_SRLV  = 6'd14, OP_SRAV  = 6'd15;
   localparam logic [5:0] OP_JR    = 6'd16, OP_ADDI  = 6'd17, OP_ADDIU = 6'd18, OP_ANDI  = 6'd19;
   localparam logic [5:0] OP_ORI   = 6'd20, OP_XORI  = 6'd21, OP_LW    = 6'd22, OP_SW    = 6'd23;
   localparam logic [5:0] OP_BEQ   = 6'd24, OP_BNE   = 6'd25, OP_SLTI  = 6'd26, OP_SLTIU = 6'd27;
   localparam logic [5:0] OP_LUI   = 6'd28, OP_J     = 6'd29, OP_JAL   = 6'd30, OP_CLZ   = 6'd31;
   localparam logic [5:0] OP_DIVU  = 6'd32, OP_ERET  = 6'd33, OP_JALR  = 6'd34, OP_LB    = 6'd35;
   localparam logic [5:0] OP_LBU   = 6'd36, OP_LHU   = 6'd37, OP_SB    = 6'd38, OP_SH    = 6'd39;
   localparam logic [5:0] OP_LH    = 6'd40, OP_MFC0  = 6'd41, OP_MFHI  = 6'd42, OP_MFLO  = 6'd43;
   localparam logic [5:0] OP_MTC0  = 6'd44, OP_MTHI  = 6'd45, OP_MTLO  = 6'd46, OP_MUL   = 6'd47;
   localparam logic [5:0] OP_MULTU = 6'd48, OP_SYSC  = 6'd49, OP_TEQ   = 6'd50, OP_BGEZ  = 6'd51;
   localparam logic [5:0] OP_BREAK = 6'd52, OP_DIV   = 6'd53;

   localparam logic [4:0] Z5 = 5'b00000;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

   function automatic logic [31:0] encode(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [15:0] imm,
                                          input logic [25:0] tgt);
      logic [31:0] w;
      case (op)
         OP_ADD:   w = r_word(rs, rt, rd, Z5, 6'h20);
         OP_ADDU:  w = r_word(rs, rt, rd, Z5, 6'h21);
         OP_SUB:   w = r_word(rs, rt, rd, Z5, 6'h22);
         OP_SUBU:  w = r_word(rs, rt, rd, Z5, 6'h23);
         OP_AND:   w = r_word(rs, rt, rd, Z5, 6'h24);
         OP_OR:    w = r_word(rs, rt, rd, Z5, 6'h25);
         OP_XOR:   w = r_word(rs, rt, rd, Z5, 6'h26);
         OP_NOR:   w = r_word(rs, rt, rd, Z5, 6'h27);
         OP_SLT:   w = r_word(rs, rt, rd, Z5, 6'h2A);
         OP_SLTU:  w = r_word(rs, rt, rd, Z5, 6'h2B);
         OP_SLL:   w = r_word(Z5, rt, rd, sh, 6'h00);
         OP_SRL:   w = r_word(Z5, rt, rd, sh, 6'h02);
         OP_SRA:   w = r_word(Z5, rt, rd, sh, 6'h03);
         OP_SLLV:  w = r_word(rs, rt, rd, Z5, 6'h04);
         OP_SRLV:  w = r_word(rs, rt, rd, Z5, 6'h06);
         OP_SRAV:  w = r_word(rs, rt, rd, Z5, 6'h07);
         OP_JR:    w = r_word(rs, Z5, Z5, Z5, 6'h08);
         OP_JALR:  w = r_word(rs, Z5, rd, Z5, 6'h09);
         OP_MFHI:  w = r_word(Z5, Z5, rd, Z5, 6'h10);
         OP_MTHI:  w = r_word(rs, Z5, Z5, Z5, 6'h11);
         OP_MFLO:  w = r_word(Z5, Z5, rd, Z5, 6'h12);
         OP_MTLO:  w = r_word(rs, Z5, Z5, Z5, 6'h13);
         OP_MULTU: w = r_word(rs, rt, Z5, Z5, 6'h19);
         OP_DIV:   w = r_word(rs, rt, Z5, Z5, 6'h1A);
         OP_DIVU:  w = r_word(rs, rt, Z5, Z5, 6'h1B);
         OP_TEQ:   w = r_word(rs, rt, Z5, Z5, 6'h34);
         OP_SYSC:  w = 32'h0000_000C;
         OP_BREAK: w = 32'h0000_000D;
         OP_ERET:  w = 32'h4200_0018;
         OP_ADDI:  w = i_word(6'h08, rs, rt, imm);
         OP_ADDIU: w = i_word(6'h09, rs, rt, imm);
         OP_SLTI:  w = i_word(6'h0A, rs, rt, imm);
         OP_SLTIU: w = i_word(6'h0B, rs, rt, imm);
         OP_ANDI:  w = i_word(6'h0C, rs, rt, imm);
         OP_ORI:   w = i_word(6'h0D, rs, rt, imm);
         OP_XORI:  w = i_word(6'h0E, rs, rt, imm);
         OP_LUI:   w = i_word(6'h0F, Z5, rt, imm);
         OP_BEQ:   w = i_word(6'h04, rs, rt, imm);
         OP_BNE:   w = i_word(6'h05, rs, rt, imm);
         OP_BGEZ:  w = i_word(6'h01, rs, 5'b00001, imm);
         OP_LB:    w = i_word(6'h20, rs, rt, imm);
         OP_LH:    w = i_word(6'h21, rs, rt, imm);
         OP_LW:    w = i_word(6'h23, rs, rt, imm);
         OP_LBU:   w = i_word(6'h24, rs, rt, imm);
         OP_LHU:   w = i_word(6'h25, rs, rt, imm);
         OP_SB:    w = i_word(6'h28, rs, rt, imm);
         OP_SH:    w = i_word(6'h29, rs, rt, imm);
         OP_SW:    w = i_word(6'h2B, rs, rt, imm);
         OP_J:     w = {6'h02, tgt};
         OP_JAL:   w = {6'h03, tgt};
         OP_CLZ:   w = {6'h1C, rs, rd, rd, Z5, 6'h20};
         OP_MUL:   w = {6'h1C, rs, rt, rd, Z5, 6'h02};
         OP_MFC0:  w = {6'h10, 5'b00000, rt, rd, 11'd0};
         OP_MTC0:  w = {6'h10, 5'b00100, rt, rd, 11'd0};
         default:  w = 32'h0000_0000;
      endcase
      return w;
   endfunction

   state_e         state_q, state_d;
   logic           pend_q, pend_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [AW-1:0]  nxt_q, nxt_d;
   logic [AW:0]    cnt_q, cnt_d;
   logic           bad_q, bad_d;
   logic           ovf_q, ovf_d;
   logic           fin_q, fin_d;
   logic           arm_q, arm_d;

   logic           accept_s;
   logic           op_ok_s;
   logic           load_s;
   logic           complete_s;
   logic           at_top_s;
   logic [31:0]    encoded_s;

   assign op_ok_s    = (op_id_i <= 6'd53);
   assign accept_s   = in_valid_i & in_ready_o;
   assign load_s     = accept_s & op_ok_s & ~start_i;
   assign complete_s = pend_q & imem_ready_i;
   assign at_top_s   = &nxt_q;
   assign encoded_s  = encode(op_id_i, rs_i, rt_i, rd_i, shamt_i, imm_i, target_i);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; fin_q marks that the final word (or final bad op) is in.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_RUN;
            else         state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (start_i)                                      state_d = ST_RUN;
            else if (fin_q && (!pend_q || imem_ready_i))      state_d = ST_DONE;
            else                                              state_d = ST_RUN;
         end
         ST_DONE: begin
            if (start_i) state_d = ST_RUN;
            else         state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode from the state register.
   always_comb begin
      busy_o     = 1'b0;
      done_o     = 1'b0;
      in_ready_o = 1'b0;
      case (state_q)
         ST_RUN: begin
            busy_o     = 1'b1;
            in_ready_o = ~fin_q & (~pend_q | imem_ready_i);
         end
         ST_DONE: done_o = 1'b1;
         default: begin
            busy_o     = 1'b0;
            done_o     = 1'b0;
            in_ready_o = 1'b0;
         end
      endcase
   end

   // Datapath next state: output register, address/count and sticky flags.
   always_comb begin
      pend_d  = pend_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      nxt_d   = nxt_q;
      cnt_d   = cnt_q;
      bad_d   = bad_q;
      ovf_d   = ovf_q;
      fin_d   = fin_q;
      arm_d   = arm_q;
      if (start_i) begin
         pend_d = 1'b0;
         nxt_d  = base_addr_i;
         cnt_d  = {(AW+1){1'b0}};
         bad_d  = 1'b0;
         ovf_d  = 1'b0;
         fin_d  = 1'b0;
         arm_d  = 1'b0;
      end else begin
         if (load_s) begin
            pend_d  = 1'b1;
            wdata_d = encoded_s;
            addr_d  = nxt_q;
            nxt_d   = nxt_q + {{(AW-1){1'b0}}, 1'b1};
         end else if (complete_s) begin
            pend_d = 1'b0;
         end else begin
            pend_d = pend_q;
         end
         if (complete_s) cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
         else            cnt_d = cnt_q;
         if (accept_s && !op_ok_s) bad_d = 1'b1;
         else                      bad_d = bad_q;
         // The last address closes the program just like in_last does.
         if (accept_s && (in_last_i || (op_ok_s && at_top_s))) fin_d = 1'b1;
         else                                                  fin_d = fin_q;
         if (load_s && at_top_s && !in_last_i) arm_d = 1'b1;
         else                                  arm_d = arm_q;
         if (arm_q && complete_s) ovf_d = 1'b1;
         else                     ovf_d = ovf_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= 1'b0;
         addr_q  <= {AW{1'b0}};
         wdata_q <= 32'h0000_0000;
         nxt_q   <= {AW{1'b0}};
         cnt_q   <= {(AW+1){1'b0}};
         bad_q   <= 1'b0;
         ovf_q   <= 1'b0;
         fin_q   <= 1'b0;
         arm_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         nxt_q   <= nxt_d;
         cnt_q   <= cnt_d;
         bad_q   <= bad_d;
         ovf_q   <= ovf_d;
         fin_q   <= fin_d;
         arm_q   <= arm_d;
      end
   end

   assign imem_we_o    = pend_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign word_cnt_o   = cnt_q;
   assign err_bad_op_o = bad_q;
   assign overflow_o   = ovf_q;

endmodule

// File: doc/instr_enc.md
Name: instr_enc

Overview:
- Instruction encoder and IMEM loader for the 54-instruction CPU; it performs the inverse of the CPU decoder's mapping.
- Accepts a stream of symbolic instructions: a binary op_id plus operand fields. Each is encoded into a canonical 32-bit MIPS word.
- Encoded words are written sequentially into instruction memory starting at a programmable base address.
- Used by the self-test/boot path to build programs in IMEM without an external assembler.

Parameters:
- AW, 10, IMEM word-address width (IMEM depth = 2^AW words).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: latch base_addr, clear counters and flags, enter RUN.
- base_addr  in  AW  first IMEM word address.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  encoder can accept an instruction this cycle.
- in_last  in  1  qualifies the final instruction of the program.
- op_id  in  6  instruction number, 0..53. Equals the bit position in the decoder's one-hot instr_index (0 add … 53 div).
- rs, rt, rd, shamt  in  5 each  register/shift fields.
- imm  in  16  I-type immediate or branch offset.
- target  in  26  J-type target.
- imem_we  out  1  write strobe.
- imem_ready  in  1  IMEM accepts the write this cycle.
- imem_addr  out  AW  write word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.
- word_cnt  out  AW+1  words written since start.
- err_bad_op  out  1  sticky; an op_id > 53 was received.
- overflow  out  1  sticky; address space exhausted before in_last.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - imem_we = 0; imem_addr, imem_wdata, word_cnt = 0.
  - err_bad_op = 0, overflow = 0, in_ready = 0.
- Reset mid-RUN abandons the pending write immediately.
- FSM IDLE → RUN on start.
- RUN → DONE when the in_last instruction's write completes (imem_we & imem_ready), or on overflow.
- DONE → RUN on start; start in RUN restarts and drops any pending write.
- One-entry output register, "pend" = imem_we:
  - in_ready = (state == RUN) & (!pend | imem_ready).
  - Accepting (in_valid & in_ready) a valid op loads imem_wdata = enc(fields) and imem_addr = next address, and sets pend on the next edge.
  - Latency from accept to imem_we is 1 cycle. Full throughput is 1 word/cycle while imem_ready = 1.
  - pend clears on imem_ready unless a new word loads the same cycle.
  - imem_wdata and imem_addr are held stable while pend & !imem_ready.
- Address and count:
  - The next address starts at base_addr and increments per accepted valid op.
  - word_cnt increments on each completed write.
  - If the accepted word targets address 2^AW−1 without in_last: that word is still written, then overflow = 1, state → DONE after its completion, and in_ready = 0 from the accept onward.
- Bad op (op_id > 53):
  - The input is accepted (consumed) and err_bad_op is set.
  - No word is written and the address is not advanced.
  - If it carries in_last, DONE is entered after any pending write completes.
- Encoding (unused fields forced to 0):
  - add/addu/sub/subu/and/or/xor/nor/slt/sltu/sllv/srlv/srav: {000000, rs, rt, rd, 00000, funct}.
  - sll/srl/sra: {000000, 00000, rt, rd, shamt, funct}.
  - jr: {000000, rs, 15'b0, 001000}.
  - jalr: {000000, rs, 00000, rd, 00000, 001001}.
  - mfhi/mflo: rd only. mthi/mtlo: rs only.
  - div/divu/multu/teq: {000000, rs, rt, 10'b0, funct}.
  - syscall = 0x0000000C; break = 0x0000000D; eret = 0x42000018.
  - addi/addiu/andi/ori/xori/slti/sltiu/lw/sw/lb/lbu/lh/lhu/sb/sh/beq/bne: {op, rs, rt, imm}.
  - lui: rs = 0.
  - bgez: {000001, rs, 00001, imm}.
  - j/jal: {op, target}.
  - clz: {011100, rs, rd, rd, 00000, 100000}.
  - mul: {011100, rs, rt, rd, 00000, 000010}.
  - mfc0: {010000, 00000, rt, rd, 11'b0}.
  - mtc0: {010000, 00100, rt, rd, 11'b0}.
- in_valid while not RUN is ignored (in_ready = 0).

Test Plan:
- start with base 0x010, then op 0 (add) rs=1 rt=2 rd=3 → one cycle later imem_we=1, addr 0x010, data 0x00221820.
- Back-to-back stream addi(17) rs=1 rt=2 imm=0xFFFF; sll(10) rt=1 rd=2 shamt=4; j(29) target=0x0100000 with in_last, imem_ready=1 → data 0x2022FFFF, 0x00011100, 0x08100000 at consecutive addresses; done=1, word_cnt=3.
- eret(33); mtc0(44) rt=8 rd=12; bgez(51) rs=4 imm=3; imem_ready low 3 cycles on the 2nd word → data 0x42000018, 0x40886000, 0x04810003. During the stall, data is held and in_ready=0.
- op_id=60 between two adds → err_bad_op=1, only 2 words written, at consecutive addresses.
- AW=4, base 0xE, 4 instructions without in_last → words at 0xE and 0xF, then overflow=1, done=1, word_cnt=2.
- Assert rst_n low while pend with imem_ready=0 → imem_we=0 and all outputs zero immediately; state = IDLE.
